// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared definitions for the pulse period meter.
//   meter_state_t : measurement FSM states (IDLE, MEASURE)
//   DEFAULT_CNT_W : default counter/period width (26 bits covers one
//                   second at 50 MHz)
package pulse_meter_pkg;

  localparam int unsigned DEFAULT_CNT_W = 26;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/pulse_period_meter_edge.sv
// rise_edge_detect: rising-edge detector for the pulse period meter tick.
// Optional macro PULSE_PERIOD_METER_SYNC_EN inserts a 2-flop synchronizer
// (reset 0) ahead of the edge detector for asynchronous pins; without it
// tick_in must already be synchronous to clk.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   tick_in   in   raw tick (pulse or level)
//   tick_edge out  one-cycle strobe on each sampled rising edge
module rise_edge_detect
  import pulse_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tick_in,
  output logic tick_edge
);

  logic tick_s;
  logic tick_d;

`ifdef PULSE_PERIOD_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], tick_in};
    end
  end

  assign tick_s = sync_q[1];
`else
  assign tick_s = tick_in;
`endif

  // tick_d resets to 0, so a tick held high across reset release is
  // seen as a rising edge. The soft clear deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick_s;
    end
  end

  assign tick_edge = tick_s & ~tick_d;

endmodule

// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures the number of clk cycles between
// consecutive rising edges of tick_in and presents each result on a
// valid/ready output with sticky overflow/overrun status.
// Optional macro PULSE_PERIOD_METER_SYNC_EN (see rise_edge_detect) adds a
// 2-flop input synchronizer; measured values are identical either way,
// only the latency from tick_in grows by 2 cycles.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   tick_in      in   tick input, only rising edges are measured
//   clear        in   synchronous soft clear (period value is kept)
//   period       out  last captured interval in cycles
//   period_valid out  period holds an unconsumed result
//   period_ready in   consumer accepts period when valid is high
//   overflow     out  sticky: counter saturated before the next edge
//   overrun      out  sticky: a result was dropped (output not consumed)
//   busy         out  high while measuring
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overflow,
  output logic             overrun,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  meter_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tick_edge;
  logic             capture;
  logic             ovf_set;

  rise_edge_detect u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_in   (tick_in),
    .tick_edge (tick_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt is 1 on the cycle after an edge, so an edge N cycles later
  // captures exactly N. At CNT_MAX without an edge the interval is
  // abandoned rather than wrapped.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    ovf_set = 1'b0;
    if (clear) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tick_edge) begin
            cnt_n   = CNT_ONE;
            state_n = MEASURE;
          end
        end
        MEASURE: begin
          if (tick_edge) begin
            capture = 1'b1;
            cnt_n   = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            ovf_set = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Output register: a capture may load when the slot is empty or being
  // drained this same cycle; otherwise the old value is held and the
  // loss is recorded in overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      overrun      <= 1'b0;
    end else if (clear) begin
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end
      if (capture) begin
        if (!period_valid || period_ready) begin
          period       <= cnt;
          period_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (period_valid && period_ready) begin
        period_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == MEASURE);

endmodule
